bisquare_win_u: RTL and testbench

//  Unary-domain squarer: the inverse of the unary square-root kernel.
//  - Squares a unipolar input bitstream by ANDing it with a decorrelated, delayed copy of itself.
//    The delayed copy comes from a shift register with a random tap.
//  - Output stream `out` has probability ~p(in)^2.
//  - A windowed counter decodes `out` to binary over 2^WIN_LOG samples, returned over a valid/ready handshake.
//  - Sits after sqrt/other unary kernels in the sqrt->square round-trip accuracy chain.

---
 rtl/bisquare_win_u.sv | 120 ++++++++++++
 tb/tb_bisquare_win_u.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bisquare_win_u.sv
// Unary squarer: ANDs the input stream with a randomly tapped delayed copy, then
// decodes the result over a 2^WIN_LOG window. Optional macro: BISQUARE_OUTREG_EN (registered out).
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | counting ones of the sampled stream over the window
// DONE  | sum held with sum_valid until the consumer accepts it
`default_nettype none

module bisquare_win_u #(
  parameter int DEP_SR    = 4,
  parameter int DEPLOG_SR = 2,
  parameter int WIN_LOG   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DEPLOG_SR-1:0] randNum,
  input  logic                 in,
  output logic                 out,
  input  logic                 start,
  output logic                 busy,
  output logic [WIN_LOG:0]     sum,
  output logic                 sum_valid,
  input  logic                 sum_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [DEP_SR-1:0]  r_sr;
  logic [1:0]         r_state;
  logic [WIN_LOG:0]   r_acc;
  logic [WIN_LOG-1:0] r_cnt;
  logic [WIN_LOG:0]   r_sum;
  logic               r_sum_valid;
  logic               w_sr_out;
  logic               w_sq;
  logic               w_sample;
  logic [WIN_LOG:0]   w_acc_next;

  // sr[k] holds `in` from (DEP_SR-k) cycles ago; reset pattern is sr[i] = i%2
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEP_SR; i++) r_sr[i] <= 1'(i % 2);
    end else begin
      r_sr <= {in, r_sr[DEP_SR-1:1]};
    end
  end

  assign w_sr_out = r_sr[randNum];
  assign w_sq     = in & w_sr_out;

`ifdef BISQUARE_OUTREG_EN
  logic r_out;

  always_ff @(posedge clk) begin
    if (rst) r_out <= 1'b0;
    else     r_out <= w_sq;
  end

  // Counting the registered bit keeps sum consistent with what the port showed
  assign out      = r_out;
  assign w_sample = r_out;
`else
  assign out      = w_sq;
  assign w_sample = w_sq;
`endif

  assign w_acc_next = r_acc + (WIN_LOG+1)'(w_sample);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        ACCUM: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {WIN_LOG{1'b1}}) begin
            r_sum       <= w_acc_next;
            r_sum_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (r_sum_valid && sum_ready) begin
            r_sum_valid <= 1'b0;
            if (start) begin
              r_state <= ACCUM;
              r_acc   <= '0;
              r_cnt   <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = (r_state == ACCUM) || (r_state == DONE);
  assign sum       = r_sum;
  assign sum_valid = r_sum_valid;

endmodule

`default_nettype wire

// File: tb/tb_bisquare_win_u.sv
// Directed bench for bisquare_win_u: stream taps, window decode, handshake stall and reset abort.
`timescale 1ns/1ps

module tb_bisquare_win_u;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] tb_rand;
  logic       tb_in;
  logic       tb_out;
  logic       tb_start;
  logic       tb_busy;
  logic [8:0] tb_sum;
  logic       tb_sum_valid;
  logic       tb_sum_ready;
  logic       alt;

  int checks   = 0;
  int failures = 0;

  bisquare_win_u #(.DEP_SR(4), .DEPLOG_SR(2), .WIN_LOG(8)) dut (
    .clk(clk), .rst(rst), .randNum(tb_rand), .in(tb_in), .out(tb_out),
    .start(tb_start), .busy(tb_busy), .sum(tb_sum), .sum_valid(tb_sum_valid),
    .sum_ready(tb_sum_ready)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are observed just after the falling edge
  task automatic tick();
    @(negedge clk);
    if (alt) tb_in = ~tb_in;
    #1;
  endtask

  task automatic pulse_start();
    tb_start = 1'b1;
    tick();
    tb_start = 1'b0;
  endtask

  task automatic wait_valid(output int n, output int ones);
    n = 0;
    ones = 0;
    while (!tb_sum_valid && n < 400) begin
      if (tb_out === 1'b1) ones++;
      tick();
      n++;
    end
  endtask

  task automatic release_sum(input string name);
    tb_sum_ready = 1'b1;
    tick();
    tb_sum_ready = 1'b0;
    checks++;
    if (tb_sum_valid !== 1'b0 || tb_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_release: valid=%0b busy=%0b required valid=0 busy=0", name, tb_sum_valid, tb_busy);
    end
  endtask

  task automatic run_window(input string name, input int exp_sum, input int exp_ones);
    int n, ones;
    pulse_start();
    checks++;
    if (tb_busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy: got %0b required 1", name, tb_busy);
    end
    wait_valid(n, ones);
    checks++;
    if (n !== 256) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles required 256", name, n);
    end
    checks++;
    if (tb_sum !== 9'(exp_sum)) begin
      failures++;
      $display("FAIL %s_sum: got %0d required %0d", name, tb_sum, exp_sum);
    end
    checks++;
    if (ones !== exp_ones) begin
      failures++;
      $display("FAIL %s_out_ones: got %0d required %0d", name, ones, exp_ones);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (tb_busy !== 1'b0 || tb_sum_valid !== 1'b0 || tb_sum !== 9'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%0b valid=%0b sum=%0d required 0 0 0", tb_busy, tb_sum_valid, tb_sum);
    end
    rst = 1'b0;
    tick();
    tb_sum_ready = 1'b1;
    tick(); tick();
    tb_sum_ready = 1'b0;
    checks++;
    if (tb_busy !== 1'b0 || tb_sum_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready: busy=%0b valid=%0b required 0 0", tb_busy, tb_sum_valid);
    end
  endtask

  task automatic test_reset_tap();
    logic exp_first [2];
    exp_first[0] = 1'b0;
    exp_first[1] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      rst = 1'b1;
      tb_in = 1'b1;
      tb_rand = 2'(r);
      tick();
      rst = 1'b0;
`ifdef BISQUARE_OUTREG_EN
      checks++;
      if (tb_out !== 1'b0) begin
        failures++;
        $display("FAIL reset_outreg: got %0b required 0", tb_out);
      end
      tick();
`endif
      checks++;
      if (tb_out !== exp_first[r]) begin
        failures++;
        $display("FAIL first_sq_rand%0d: got %0b required %0b", r, tb_out, exp_first[r]);
      end
    end
  endtask

  task automatic test_const();
    alt = 1'b0;
    tb_rand = 2'd1;
    tb_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    run_window("const1", 256, 256);
    release_sum("const1");
    tb_in = 1'b0;
    tb_rand = 2'd3;
    for (int i = 0; i < 6; i++) tick();
    run_window("const0", 0, 0);
    release_sum("const0");
  endtask

  task automatic test_alternating();
    alt = 1'b1;
    tb_in = 1'b0;
    tb_rand = 2'd3;
    for (int i = 0; i < 8; i++) tick();
    run_window("alt_d1", 0, 0);
    release_sum("alt_d1");
    tb_rand = 2'd2;
    for (int i = 0; i < 8; i++) tick();
`ifndef BISQUARE_OUTREG_EN
    checks++;
    if (tb_out !== tb_in) begin
      failures++;
      $display("FAIL alt_d2_follow: out=%0b required %0b", tb_out, tb_in);
    end
`endif
    run_window("alt_d2", 128, 128);
    release_sum("alt_d2");
    alt = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n, ones;
    tb_in = 1'b1;
    tb_rand = 2'd0;
    for (int i = 0; i < 6; i++) tick();
    run_window("stall", 256, 256);
    for (int k = 0; k < 10; k++) begin
      tb_start = 1'(k % 2);
      tick();
      checks++;
      if (tb_sum !== 9'd256 || tb_sum_valid !== 1'b1 || tb_busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold%0d: sum=%0d valid=%0b busy=%0b required 256 1 1", k, tb_sum, tb_sum_valid, tb_busy);
      end
    end
    tb_start = 1'b1;
    tb_sum_ready = 1'b1;
    tick();
    tb_start = 1'b0;
    tb_sum_ready = 1'b0;
    checks++;
    if (tb_busy !== 1'b1 || tb_sum_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart: busy=%0b valid=%0b required 1 0", tb_busy, tb_sum_valid);
    end
    wait_valid(n, ones);
    checks++;
    if (n !== 256 || tb_sum !== 9'd256) begin
      failures++;
      $display("FAIL b2b_window: cycles=%0d sum=%0d required 256 256", n, tb_sum);
    end
    release_sum("b2b");
  endtask

  task automatic test_rst_abort();
    tb_in = 1'b1;
    tb_rand = 2'd1;
    pulse_start();
    for (int i = 0; i < 100; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (tb_sum_valid !== 1'b0 || tb_busy !== 1'b0 || tb_sum !== 9'd0) begin
      failures++;
      $display("FAIL abort_state: valid=%0b busy=%0b sum=%0d required 0 0 0", tb_sum_valid, tb_busy, tb_sum);
    end
    for (int i = 0; i < 5; i++) tick();
    run_window("after_abort", 256, 256);
    release_sum("after_abort");
  endtask

  initial begin
    rst = 1'b1;
    tb_rand = 2'd0;
    tb_in = 1'b0;
    tb_start = 1'b0;
    tb_sum_ready = 1'b0;
    alt = 1'b0;
    test_reset();
    test_reset_tap();
    test_const();
    test_alternating();
    test_back_to_back();
    test_rst_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
